// File: rtl/counter_mod_updown_if.sv
// Control and status bundle for counter_mod_updown.
// The master drives the count controls and the slave returns count and wrap flag.
interface counter_mod_updown_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] O;
  logic             COUT;

  modport master (output CE, output UP, output LD, output DI, input O, input COUT);
  modport slave  (input CE, input UP, input LD, input DI, output O, output COUT);
endinterface

// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with synchronous load, count enable and a
// registered wrap flag.
// The edge priority is reset, then load, then count, then hold.
// Arithmetic is done one bit wider than the count, so the terminal compare
// stays explicit even when MODULUS equals 2**WIDTH.
module counter_mod_updown #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256,
  parameter longint INIT    = 0
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  counter_mod_updown_if.slave  bus
);

  // Reject parameter combinations that could produce an out-of-range count.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod_updown: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS must be 2..2**WIDTH");
  end
  if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
    $error("counter_mod_updown: INIT must be below MODULUS");
  end

  localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   LAST_W = MOD_W - 1'b1;
  localparam logic [WIDTH:0]   ONE_W  = 1;
  localparam logic [WIDTH:0]   ZERO_W = '0;
  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];

  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic             cout_q;
  logic             cout_d;
  logic [WIDTH:0]   o_ext;
  logic [WIDTH:0]   di_ext;

  // Next count and wrap flag. The flag defaults low, so it never stretches over idle cycles.
  always_comb begin
    o_d    = o_q;
    cout_d = 1'b0;
    o_ext  = {1'b0, o_q};
    di_ext = {1'b0, bus.DI};
    if (bus.LD) begin
      // An out-of-range load saturates to the terminal value.
      if (di_ext < MOD_W) begin
        o_d = bus.DI;
      end else begin
        o_d = WIDTH'(LAST_W);
      end
    end else if (bus.CE) begin
      if (bus.UP) begin
        if (o_ext == LAST_W) begin
          o_d    = '0;
          cout_d = 1'b1;
        end else begin
          o_d = WIDTH'(o_ext + ONE_W);
        end
      end else begin
        if (o_ext == ZERO_W) begin
          o_d    = WIDTH'(LAST_W);
          cout_d = 1'b1;
        end else begin
          o_d = WIDTH'(o_ext - ONE_W);
        end
      end
    end
  end

  // State register. Reset discards both the count and any pending wrap flag.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      o_q    <= INIT_V;
      cout_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.COUT = cout_q;

endmodule
